// File: rtl/k12a_pkg.sv
// Shared k12a types: sequencer state encoding (STATE_IRQ always encoded).
package k12a_pkg;

  typedef enum logic [2:0] {
    STATE_FETCH1 = 3'd0,
    STATE_FETCH2 = 3'd1,
    STATE_FETCH3 = 3'd2,
    STATE_EXEC   = 3'd3,
    STATE_POP    = 3'd4,
    STATE_RJMP   = 3'd5,
    STATE_HALT   = 3'd6,
    STATE_IRQ    = 3'd7
  } state_t;

  // Decoder targets EXEC may legally hand off to.
  function automatic logic legal_exec_next(state_t s);
    return (s == STATE_FETCH1) || (s == STATE_POP) ||
           (s == STATE_RJMP)   || (s == STATE_HALT);
  endfunction

endpackage

// File: rtl/k12a_seq_wait.sv
// Memory-phase wait counter with minimum-wait and timeout compares.
module k12a_seq_wait #(
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              count,
  output logic [WAIT_W-1:0] wait_count,
  output logic              ready_ok,
  output logic              timeout
);

  always_ff @(posedge clock) begin
    if (!reset_n)   wait_count <= '0;
    else if (clear) wait_count <= '0;
    else if (count) wait_count <= wait_count + WAIT_W'(1);
  end

  // A zero minimum wait makes every cycle eligible; avoids an always-true compare.
  generate
    if (MEM_WAIT == 0) begin : g_nowait
      assign ready_ok = 1'b1;
    end else begin : g_wait
      assign ready_ok = (wait_count >= WAIT_W'(MEM_WAIT));
    end
  endgenerate

  assign timeout = (wait_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/k12a_sequencer.sv
// K12A instruction sequencer: fetch/exec state machine with memory waits and bus timeout.
// Optional interrupt entry state enabled by defining K12A_SEQ_IRQ_EN.
module k12a_sequencer
  import k12a_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              exec_mem,
  input  state_t            exec_next,
  input  logic              mem_ready,
  input  logic              wake,
`ifdef K12A_SEQ_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
`endif
  output state_t            state,
  output logic              advance,
  output logic              mem_busy,
  output logic [WAIT_W-1:0] wait_count,
  output logic [CNT_W-1:0]  retired,
  output logic              bus_error
);

  state_t state_next;
  logic   mem_phase, ready_ok, timeout, fire_to, halt_leave, irq_req;

`ifdef K12A_SEQ_IRQ_EN
  assign irq_req = irq;
  assign irq_ack = (state == STATE_IRQ);
`else
  assign irq_req = 1'b0;
`endif

  k12a_seq_wait #(
    .MEM_WAIT(MEM_WAIT),
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (!mem_phase || advance || timeout),
    .count     (mem_busy),
    .wait_count(wait_count),
    .ready_ok  (ready_ok),
    .timeout   (timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= STATE_FETCH1;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)     bus_error <= 1'b0;
    else if (fire_to) bus_error <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                           retired <= '0;
    else if (state == STATE_EXEC && advance) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      STATE_FETCH1: if (advance) state_next = STATE_FETCH2;
                    else if (fire_to) state_next = STATE_HALT;
      STATE_FETCH2: if (advance) state_next = STATE_FETCH3;
                    else if (fire_to) state_next = STATE_HALT;
      STATE_FETCH3: state_next = STATE_EXEC;
      STATE_EXEC:   if (advance) state_next = legal_exec_next(exec_next) ? exec_next : STATE_FETCH1;
                    else if (fire_to) state_next = STATE_HALT;
      STATE_POP,
      STATE_RJMP:   state_next = STATE_FETCH1;
      STATE_HALT:   if (halt_leave) state_next = STATE_FETCH1;
      default:      state_next = STATE_FETCH1;
    endcase
    // Interrupts are taken on the way into FETCH1, never out of STATE_IRQ itself.
    if (irq_req && state_next == STATE_FETCH1 && state != STATE_IRQ && state != STATE_FETCH1)
      state_next = STATE_IRQ;
  end

  always_comb begin
    mem_phase  = (state == STATE_FETCH1) || (state == STATE_FETCH2) ||
                 (state == STATE_EXEC && exec_mem);
    halt_leave = !bus_error && (wake || irq_req);
    advance    = 1'b1;
    if (mem_phase)                advance = ready_ok && mem_ready;
    else if (state == STATE_HALT) advance = halt_leave;
    mem_busy   = mem_phase && !advance;
    fire_to    = mem_busy && timeout;
  end

endmodule
